// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared FSM states and timing constants for the RO PUF controller
package ro_puf_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_COUNT, ST_DRAIN, ST_COMPARE, ST_DONE} state_e;
   localparam int DRAIN_CYCLES = 2;
   localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/ro_edge_cnt.sv
// ro_edge_cnt: synchronizes one raw oscillator, detects rising edges and counts them with saturation
module ro_edge_cnt
   import ro_puf_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ro_in,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);
   logic [SYNC_STAGES:0] sh_q, sh_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 rise;

   assign rise = sh_q[SYNC_STAGES-1] && !sh_q[SYNC_STAGES];
   assign cnt  = cnt_q;

   // shift the synchronizer/edge chain and advance the counter, stopping at all-ones
   always_comb begin
      sh_d  = {sh_q[SYNC_STAGES-1:0], ro_in};
      cnt_d = clr ? '0 : (en && rise && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: challenge/response sequencer for the RO PUF bank; RO_PUF_CNT_OUT_EN exposes the final counts
module ro_puf_ctrl
   import ro_puf_pkg::*;
#(
   parameter int N_RO   = 16,
   parameter int SEL_W  = $clog2(N_RO),
   parameter int CNT_W  = 16,
   parameter int WINDOW = 1024,
   parameter int SETTLE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [SEL_W-1:0] chal_a,
   input  logic [SEL_W-1:0] chal_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_bit,
   output logic             resp_tie,
   output logic             busy,
   output logic [N_RO-1:0]  ro_en,
`ifdef RO_PUF_CNT_OUT_EN
   input  logic [N_RO-1:0]  ro_out,
   output logic [CNT_W-1:0] cnt_a_out,
   output logic [CNT_W-1:0] cnt_b_out
`else
   input  logic [N_RO-1:0]  ro_out
`endif
);
   localparam int TMR_W = 21;

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [SEL_W-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
   logic             bit_q, bit_d, tie_q, tie_d;
   logic             clr, degen, ro_a, ro_b;
   logic [N_RO-1:0]  mask_a, mask_b;
   logic [CNT_W-1:0] cnt_a, cnt_b;

   // out-of-range indices shift the one-hot mask to zero, so they never select an oscillator
   assign degen      = chal_a == chal_b || 32'(chal_a) >= N_RO || 32'(chal_b) >= N_RO;
   assign mask_a     = N_RO'(1) << sel_a_q;
   assign mask_b     = N_RO'(1) << sel_b_q;
   assign ro_a       = |(ro_out & mask_a);
   assign ro_b       = |(ro_out & mask_b);
   assign req_ready  = rst_n && state_q == ST_IDLE;
   assign busy       = state_q != ST_IDLE;
   assign resp_valid = state_q == ST_DONE;
   assign resp_bit   = bit_q;
   assign resp_tie   = tie_q;
   assign ro_en      = (state_q == ST_SETTLE || state_q == ST_COUNT) ? (mask_a | mask_b) : '0;
`ifdef RO_PUF_CNT_OUT_EN
   assign cnt_a_out  = cnt_a;
   assign cnt_b_out  = cnt_b;
`endif

   ro_edge_cnt #(.CNT_W(CNT_W)) u_cnt_a (
      .clk(clk), .rst_n(rst_n), .ro_in(ro_a), .clr(clr), .en(state_q == ST_COUNT), .cnt(cnt_a)
   );

   ro_edge_cnt #(.CNT_W(CNT_W)) u_cnt_b (
      .clk(clk), .rst_n(rst_n), .ro_in(ro_b), .clr(clr), .en(state_q == ST_COUNT), .cnt(cnt_b)
   );

   // next state: each timed phase loads its length minus one and leaves when the timer hits zero
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q - TMR_W'(1);
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      bit_d   = bit_q;
      tie_d   = tie_q;
      clr     = 1'b0;
      unique case (state_q)
         ST_IDLE: if (req_valid) begin
            sel_a_d = chal_a;
            sel_b_d = chal_b;
            clr     = 1'b1;
            bit_d   = 1'b0;
            tie_d   = degen;
            tmr_d   = TMR_W'(SETTLE - 1);
            state_d = degen ? ST_DONE : ST_SETTLE;
         end
         ST_SETTLE: if (tmr_q == '0) begin
            tmr_d   = TMR_W'(WINDOW - 1);
            state_d = ST_COUNT;
         end
         ST_COUNT: if (tmr_q == '0) begin
            tmr_d   = TMR_W'(DRAIN_CYCLES - 1);
            state_d = ST_DRAIN;
         end
         ST_DRAIN: state_d = tmr_q == '0 ? ST_COMPARE : ST_DRAIN;
         ST_COMPARE: begin
            bit_d   = cnt_a > cnt_b;
            tie_d   = cnt_a == cnt_b;
            state_d = ST_DONE;
         end
         ST_DONE: state_d = resp_ready ? ST_IDLE : ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         sel_a_q <= '0;
         sel_b_q <= '0;
         bit_q   <= 1'b0;
         tie_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         bit_q   <= bit_d;
         tie_q   <= tie_d;
      end
   end
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb_ro_puf_ctrl: directed checks of the RO PUF controller with behavioural oscillators
module tb_ro_puf_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, resp_ready = 1'b0;
   logic [4:0]  chal_a = '0, chal_b = '0;
   logic        req_ready, resp_valid, resp_bit, resp_tie, busy;
   logic [15:0] ro_en, ro_out;
   logic [15:0] cnt_a_o, cnt_b_o;

   logic        s_req_valid = 1'b0, s_resp_ready = 1'b0;
   logic [3:0]  s_chal_a = '0, s_chal_b = '0;
   logic        s_req_ready, s_resp_valid, s_resp_bit, s_resp_tie, s_busy;
   logic [15:0] s_ro_en, s_ro_out;
   logic [7:0]  s_cnt_a_o, s_cnt_b_o;

   logic a_free = 1'b0, b_free = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] a, b;
      logic       bit_e, tie_e;
      int         lat, alo, ahi, blo, bhi;
   } vec_t;
   vec_t vecs[4];

   ro_puf_ctrl #(.N_RO(16), .SEL_W(5), .CNT_W(16), .WINDOW(1024), .SETTLE(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .chal_a(chal_a), .chal_b(chal_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_bit(resp_bit), .resp_tie(resp_tie), .busy(busy), .ro_en(ro_en),
`ifdef RO_PUF_CNT_OUT_EN
      .ro_out(ro_out), .cnt_a_out(cnt_a_o), .cnt_b_out(cnt_b_o)
`else
      .ro_out(ro_out)
`endif
   );

   ro_puf_ctrl #(.N_RO(16), .CNT_W(8), .WINDOW(2048), .SETTLE(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
      .chal_a(s_chal_a), .chal_b(s_chal_b), .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
      .resp_bit(s_resp_bit), .resp_tie(s_resp_tie), .busy(s_busy), .ro_en(s_ro_en),
`ifdef RO_PUF_CNT_OUT_EN
      .ro_out(s_ro_out), .cnt_a_out(s_cnt_a_o), .cnt_b_out(s_cnt_b_o)
`else
      .ro_out(s_ro_out)
`endif
   );

   initial forever #5 clk = ~clk;
   // oscillator A: 40 ns period, B: 60 ns period, phases kept off the clock edges
   initial begin #3; forever #20 a_free = ~a_free; end
   initial begin #3; forever #30 b_free = ~b_free; end

   always_comb begin
      ro_out      = '0;
      ro_out[3]   = a_free & ro_en[3];
      ro_out[7]   = b_free & ro_en[7];
      s_ro_out    = '0;
      s_ro_out[3] = a_free & s_ro_en[3];
      s_ro_out[4] = a_free & s_ro_en[4];
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic issue_wait(input logic [4:0] a, input logic [4:0] b, output int n, output bit en_ok);
      logic [15:0] m;
      bit          bad, saw;
      m = (a < 16 && b < 16 && a != b) ? (16'd1 << a) | (16'd1 << b) : 16'd0;
      @(negedge clk);
      chk("req_ready", req_ready, 1);
      req_valid = 1'b1;
      chal_a = a;
      chal_b = b;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("accept_busy", busy, 1);
      n = 1;
      bad = (ro_en & ~m) != 0;
      saw = ro_en == m;
      while (!resp_valid && n < 3000) begin
         @(posedge clk);
         #1 n++;
         if ((ro_en & ~m) != 0) bad = 1'b1;
         if (ro_en == m) saw = 1'b1;
      end
      en_ok = !bad && saw;
   endtask

   task automatic handshake();
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      chk("resp_drop", resp_valid, 0);
      chk("ready_after", req_ready, 1);
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      bit en_ok;
      issue_wait(v.a, v.b, n, en_ok);
      chk("latency", n, v.lat);
      chk("resp_bit", resp_bit, v.bit_e);
      chk("resp_tie", resp_tie, v.tie_e);
      chk_rng("cnt_a", u_dut.cnt_a, v.alo, v.ahi);
      chk_rng("cnt_b", u_dut.cnt_b, v.blo, v.bhi);
`ifdef RO_PUF_CNT_OUT_EN
      chk_rng("cnt_a_out", cnt_a_o, v.alo, v.ahi);
      chk_rng("cnt_b_out", cnt_b_o, v.blo, v.bhi);
`endif
      chk("ro_en_pair", en_ok, 1);
      handshake();
   endtask

   initial begin
      int n;
      bit en_ok, hold_bad;
      vecs[0] = '{a: 3,  b: 7, bit_e: 1, tie_e: 0, lat: 1032, alo: 255, ahi: 257, blo: 169, bhi: 172};
      vecs[1] = '{a: 7,  b: 3, bit_e: 0, tie_e: 0, lat: 1032, alo: 169, ahi: 172, blo: 255, bhi: 257};
      vecs[2] = '{a: 5,  b: 5, bit_e: 0, tie_e: 1, lat: 1,    alo: 0,   ahi: 0,   blo: 0,   bhi: 0};
      vecs[3] = '{a: 16, b: 3, bit_e: 0, tie_e: 1, lat: 1,    alo: 0,   ahi: 0,   blo: 0,   bhi: 0};

      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ro_en", ro_en, 0);
      chk("rst_resp_bit", resp_bit, 0);
      chk("rst_resp_tie", resp_tie, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_req_ready", req_ready, 1);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      issue_wait(5'd3, 5'd7, n, en_ok);
      chk("stall_latency", n, 1032);
      hold_bad = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (resp_valid !== 1'b1 || resp_bit !== 1'b1 || resp_tie !== 1'b0 || req_ready !== 1'b0 || ro_en !== 16'd0)
            hold_bad = 1'b1;
      end
      chk("stall_hold", hold_bad, 0);
      handshake();
      issue_wait(5'd5, 5'd5, n, en_ok);
      chk("b2b_latency", n, 1);
      chk("b2b_tie", resp_tie, 1);
      handshake();

      @(negedge clk);
      req_valid = 1'b1;
      chal_a = 5'd3;
      chal_b = 5'd7;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (100) @(posedge clk);
      chk("mid_count_en", ro_en, (16'd1 << 3) | (16'd1 << 7));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ro_en", ro_en, 0);
      chk("mid_rst_valid", resp_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_cnt", u_dut.cnt_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(vecs[1]);

      @(negedge clk);
      s_req_valid = 1'b1;
      s_chal_a = 4'd3;
      s_chal_b = 4'd4;
      @(posedge clk);
      #1 s_req_valid = 1'b0;
      n = 1;
      while (!s_resp_valid && n < 5000) begin
         @(posedge clk);
         #1 n++;
      end
      chk("sat_latency", n, 2056);
      chk("sat_bit", s_resp_bit, 0);
      chk("sat_tie", s_resp_tie, 1);
      chk("sat_cnt_a", u_sat.cnt_a, 255);
      chk("sat_cnt_b", u_sat.cnt_b, 255);
      @(negedge clk);
      s_resp_ready = 1'b1;
      @(posedge clk);
      #1 s_resp_ready = 1'b0;
      chk("sat_drop", s_resp_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ro_puf_ctrl.md
Name: ro_puf_ctrl

Overview:
- Sequencer for the ring-oscillator PUF array. It takes a challenge that names two oscillators, enables only those two, and counts rising edges of each over a fixed clock window.
- It compares the two counts and returns a single response bit through a valid/ready handshake.
- Sits between the challenge/response interface and the bank of `ro` instances. It drives each instance's `enable` and samples each instance's output.

Parameters:
- N_RO, 16, number of ring oscillators in the bank (>= 2).
- SEL_W, $clog2(N_RO) = 4, width of each challenge index.
- CNT_W, 16, width of each edge counter.
- WINDOW, 1024, number of clock cycles in the counting window (1..2^20).
- SETTLE, 4, cycles the oscillators run before counting starts (>= 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  1  challenge valid.
- req_ready  out  1  controller can accept a challenge.
- chal_a  in  SEL_W  index of oscillator A.
- chal_b  in  SEL_W  index of oscillator B.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_bit  out  1  1 when count_A > count_B, otherwise 0.
- resp_tie  out  1  set when count_A == count_B, or when the challenge is degenerate.
- busy  out  1  high in every state except IDLE.
- ro_en  out  N_RO  per-oscillator enable, driven to the `enable` input of each `ro`.
- ro_out  in  N_RO  raw oscillator outputs, asynchronous to clk.

Behaviour:
- Reset values: req_ready=0 while rst_n is low, then 1 in IDLE. resp_valid=0, resp_bit=0, resp_tie=0, busy=0, ro_en=0. Counters and the state register clear asynchronously.
- States: IDLE -> SETTLE -> COUNT -> DRAIN -> COMPARE -> DONE -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, register chal_a/chal_b and clear both counters.
  - If chal_a == chal_b or either index >= N_RO, go straight to DONE with resp_bit=0, resp_tie=1. No oscillator is enabled on this path.
  - Otherwise go to SETTLE.
- SETTLE: ro_en has exactly the two selected bits set; all other bits are 0. Stay SETTLE cycles without counting.
- COUNT:
  - ro_en unchanged. Stay exactly WINDOW cycles.
  - Each selected output passes through a 2-flop synchronizer plus an edge register. A synchronized 0->1 transition increments that oscillator's counter.
  - Counters saturate at 2^CNT_W-1; they never wrap.
- DRAIN: ro_en=0. Stay 2 cycles. Edges seen in this state are not counted.
- COMPARE: 1 cycle. Register resp_bit = (cnt_a > cnt_b) and resp_tie = (cnt_a == cnt_b).
- DONE:
  - resp_valid=1. resp_bit and resp_tie hold stable until resp_valid && resp_ready.
  - On that handshake, go to IDLE and drop resp_valid the next cycle.
- Latency: with accept at cycle T, resp_valid rises at T+SETTLE+WINDOW+4 (defaults: T+1032). A degenerate challenge gives resp_valid at T+1.
- Back-to-back: a new request can be accepted the cycle after the DONE handshake. req_ready is 0 in all non-IDLE states.
- Mid-operation reset: ro_en clears immediately (asynchronously) and any response in flight is discarded.
- Only one pair is ever enabled, and ro_en is always 0 outside SETTLE/COUNT.
- Measurement is valid only while each RO frequency is below clk/2. Above that, counts under-read; this is the integrator's responsibility.

Optional Feature:
- Macro: RO_PUF_CNT_OUT_EN.
- With the macro defined, add outputs cnt_a_out[CNT_W] and cnt_b_out[CNT_W]. They carry the final counts, are valid alongside resp_valid, and are 0 on a degenerate challenge and on reset. Used for reliability and uniqueness characterization.
- Without it, these ports do not exist and the counts stay internal.

Decomposition:
- Package ro_puf_pkg holds:
  - the state enum (IDLE, SETTLE, COUNT, DRAIN, COMPARE, DONE);
  - DRAIN_CYCLES = 2;
  - SYNC_STAGES = 2.
- One sub-module, ro_edge_cnt: synchronizer, edge detect, clear, enable and saturating counter, parameterized by CNT_W. It is instantiated twice, fed by ro_out[chal_a] and ro_out[chal_b].

Test Plan:
- Bench setup: clk 10 ns; behavioural ROs with A period 40 ns and B period 60 ns; chal_a=3, chal_b=7.
  -> resp_valid at accept+1032 cycles, resp_bit=1, resp_tie=0, counts approx. 256 and approx. 170 (±1).
- Same bench with chal_a=7, chal_b=3 -> resp_bit=0, resp_tie=0.
- Degenerate challenges: chal_a=chal_b=5, and chal_a=16 with N_RO=16.
  -> resp_valid at accept+1, resp_tie=1, resp_bit=0, ro_en stays 0 throughout.
- CNT_W=8, both ROs at a 40 ns period, WINDOW=2048.
  -> both counts saturate at 255, resp_tie=1, resp_bit=0.
- Hold resp_ready=0 for 50 cycles after resp_valid.
  -> resp_valid, resp_bit and resp_tie stay stable, req_ready=0, ro_en=0.
  -> After the handshake, the next request is accepted 1 cycle later.
- Assert rst_n low mid-COUNT.
  -> ro_en=0 in the same timestep, resp_valid=0.
  -> After release, a new challenge completes normally.
